// File: rtl/mem_access_ctrl.sv
// Sequences single-word LC-3 memory requests into ldMAR/ldMDR/selMDR/memWE/Bus steps and decodes the xFE00+ I/O page locally.
// Latency: RAM read or write -> ready in cycle 4 after the accepting edge; I/O access -> ready in cycle 2.
// Backpressure: req is sampled only in IDLE, so a new request is accepted at the earliest on the cycle after ready.
//
// Ports: clk/reset (async, active-high); req/we/addr/wdata request in; rdata/ready/busy completion out;
//        bus_out/ldMAR/ldMDR/selMDR/memWE to the memory stage, mem_q from it;
//        kb_strobe/kb_char keyboard in; dsp_ready/ddr_valid/ddr_data display side.
module mem_access_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic [15:0] bus_out,
    output logic        ldMAR,
    output logic        ldMDR,
    output logic        selMDR,
    output logic        memWE,
    input  logic [15:0] mem_q,
    input  logic        kb_strobe,
    input  logic [7:0]  kb_char,
    input  logic        dsp_ready,
    output logic        ddr_valid,
    output logic [7:0]  ddr_data
);

    localparam logic [15:0] IO_BASE   = 16'hFE00;
    localparam logic [15:0] ADDR_KBSR = 16'hFE00;
    localparam logic [15:0] ADDR_KBDR = 16'hFE02;
    localparam logic [15:0] ADDR_DSR  = 16'hFE04;
    localparam logic [15:0] ADDR_DDR  = 16'hFE06;

    typedef enum logic [2:0] {
        IDLE, LD_MAR, RD_WAIT, RD_LDMDR, WR_LDMDR, WR_MEM, IO, DONE
    } state_t;

    state_t      state;
    logic [15:0] addr_r;
    logic        we_r;
    logic [15:0] wdata_r;
    logic        kb_full;
    logic [7:0]  kbdr;
    logic        kbdr_rd;
    logic [15:0] io_rdata;

    // A KBDR read completes on the edge leaving IO; that same edge clears kb_full.
    assign kbdr_rd = (state == IO) && !we_r && (addr_r == ADDR_KBDR);

    always_comb begin
        io_rdata = 16'h0000;
        case (addr_r)
            ADDR_KBSR: io_rdata = {kb_full, 15'b0};
            ADDR_KBDR: io_rdata = {8'h00, kbdr};
            ADDR_DSR:  io_rdata = {dsp_ready, 15'b0};
            default:   io_rdata = 16'h0000;
        endcase
    end

    // Keyboard register. The read path samples kbdr before this edge updates it,
    // so a strobe coinciding with a KBDR read hands out the old character and
    // leaves the new one pending with kb_full still set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kb_full <= 1'b0;
            kbdr    <= 8'h00;
        end else if (kb_strobe && (!kb_full || kbdr_rd)) begin
            kb_full <= 1'b1;
            kbdr    <= kb_char;
        end else if (kbdr_rd) begin
            kb_full <= 1'b0;
        end
    end

    // Outputs are registered: each transition loads the control values that
    // belong to the state being entered, so every strobe is clean for a full cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            addr_r    <= 16'h0000;
            we_r      <= 1'b0;
            wdata_r   <= 16'h0000;
            rdata     <= 16'h0000;
            ready     <= 1'b0;
            busy      <= 1'b0;
            bus_out   <= 16'h0000;
            ldMAR     <= 1'b0;
            ldMDR     <= 1'b0;
            selMDR    <= 1'b0;
            memWE     <= 1'b0;
            ddr_valid <= 1'b0;
            ddr_data  <= 8'h00;
        end else begin
            ready     <= 1'b0;
            bus_out   <= 16'h0000;
            ldMAR     <= 1'b0;
            ldMDR     <= 1'b0;
            selMDR    <= 1'b0;
            memWE     <= 1'b0;
            ddr_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_r  <= addr;
                        we_r    <= we;
                        wdata_r <= wdata;
                        busy    <= 1'b1;
                        if (addr >= IO_BASE) begin
                            state <= IO;
                        end else begin
                            state   <= LD_MAR;
                            ldMAR   <= 1'b1;
                            bus_out <= addr;
                        end
                    end
                end
                LD_MAR: begin
                    if (we_r) begin
                        state   <= WR_LDMDR;
                        ldMDR   <= 1'b1;
                        bus_out <= wdata_r;
                    end else begin
                        // RAM latches the MAR address during RD_WAIT.
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    state  <= RD_LDMDR;
                    selMDR <= 1'b1;
                    ldMDR  <= 1'b1;
                end
                RD_LDMDR: begin
                    rdata <= mem_q;
                    state <= DONE;
                    ready <= 1'b1;
                end
                WR_LDMDR: begin
                    state <= WR_MEM;
                    memWE <= 1'b1;
                end
                WR_MEM: begin
                    state <= DONE;
                    ready <= 1'b1;
                end
                IO: begin
                    if (!we_r) begin
                        rdata <= io_rdata;
                    end else if (addr_r == ADDR_DDR) begin
                        ddr_data  <= wdata_r[7:0];
                        ddr_valid <= 1'b1;
                    end
                    state <= DONE;
                    ready <= 1'b1;
                end
                DONE: begin
                    // req is deliberately not sampled here.
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: memory-stage environment, transaction-level reference model, per-cycle compare.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [15:0] addr = 16'h0;
    logic [15:0] wdata = 16'h0;
    logic [15:0] rdata;
    logic        ready;
    logic        busy;
    logic [15:0] bus_out;
    logic        ldMAR, ldMDR, selMDR, memWE;
    logic [15:0] mem_q = 16'h0;
    logic        kb_strobe = 1'b0;
    logic [7:0]  kb_char = 8'h0;
    logic        dsp_ready = 1'b1;
    logic        ddr_valid;
    logic [7:0]  ddr_data;

    int n_chk = 0;
    int n_bad = 0;

    mem_access_ctrl dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .busy(busy), .bus_out(bus_out),
        .ldMAR(ldMAR), .ldMDR(ldMDR), .selMDR(selMDR), .memWE(memWE), .mem_q(mem_q),
        .kb_strobe(kb_strobe), .kb_char(kb_char), .dsp_ready(dsp_ready),
        .ddr_valid(ddr_valid), .ddr_data(ddr_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- memory stage environment (MAR, MDR, synchronous RAM) ----------------
    logic [15:0] ram [0:65535];
    logic [15:0] mar = 16'h0;
    logic [15:0] mdr = 16'h0;
    initial for (int i = 0; i < 65536; i++) ram[i] = 16'h0;

    always @(posedge clk) begin
        if (ldMAR) mar <= bus_out;
        if (ldMDR) mdr <= selMDR ? mem_q : bus_out;
        if (memWE) ram[mar] <= mdr;
        mem_q <= ram[mar];
    end

    // ---------------- reference model: transaction timeline ----------------
    logic [15:0] ref_mem [0:65535];
    initial for (int i = 0; i < 65536; i++) ref_mem[i] = 16'h0;

    bit          m_act = 0;
    int          m_cyc = 0;
    bit          m_io = 0;
    bit          m_we = 0;
    logic [15:0] m_addr = 16'h0;
    logic [15:0] m_wd = 16'h0;
    logic [15:0] m_rdata = 16'h0;
    bit          m_full = 0;
    logic [7:0]  m_kbdr = 8'h0;
    logic [7:0]  m_ddr = 8'h0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_act = 0; m_cyc = 0; m_rdata = 16'h0;
            m_full = 0; m_kbdr = 8'h0; m_ddr = 8'h0;
        end else begin
            if (m_act && m_io && m_cyc == 1) begin
                if (!m_we) begin
                    if (m_addr == 16'hFE00)      m_rdata = m_full ? 16'h8000 : 16'h0000;
                    else if (m_addr == 16'hFE02) begin m_rdata = {8'h00, m_kbdr}; m_full = 0; end
                    else if (m_addr == 16'hFE04) m_rdata = dsp_ready ? 16'h8000 : 16'h0000;
                    else                         m_rdata = 16'h0000;
                end else if (m_addr == 16'hFE06) begin
                    m_ddr = m_wd[7:0];
                end
            end
            if (m_act && !m_io && m_cyc == 3) begin
                if (m_we) ref_mem[m_addr] = m_wd;
                else      m_rdata = ref_mem[m_addr];
            end
            if (kb_strobe && !m_full) begin
                m_kbdr = kb_char;
                m_full = 1;
            end
            if (m_act) begin
                if (m_cyc == (m_io ? 2 : 4)) m_act = 0;
                else m_cyc = m_cyc + 1;
            end else if (req) begin
                m_act = 1; m_cyc = 1; m_io = (addr >= 16'hFE00);
                m_we = we; m_addr = addr; m_wd = wdata;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        int c;
        bit ram_op;
        logic [15:0] e_bus;
        c = m_act ? m_cyc : 0;
        ram_op = m_act && !m_io;
        e_bus = 16'h0;
        if (ram_op && c == 1) e_bus = m_addr;
        if (ram_op && m_we && c == 2) e_bus = m_wd;
        chk("busy", {15'b0, busy}, {15'b0, m_act});
        chk("ready", {15'b0, ready}, {15'b0, m_act && c == (m_io ? 2 : 4)});
        chk("bus_out", bus_out, e_bus);
        chk("ldMAR", {15'b0, ldMAR}, {15'b0, ram_op && c == 1});
        chk("ldMDR", {15'b0, ldMDR}, {15'b0, ram_op && ((m_we && c == 2) || (!m_we && c == 3))});
        chk("selMDR", {15'b0, selMDR}, {15'b0, ram_op && !m_we && c == 3});
        chk("memWE", {15'b0, memWE}, {15'b0, ram_op && m_we && c == 3});
        chk("rdata", rdata, m_rdata);
        chk("ddr_valid", {15'b0, ddr_valid},
            {15'b0, m_act && m_io && m_we && m_addr == 16'hFE06 && c == 2});
        chk("ddr_data", {8'h0, ddr_data}, {8'h0, m_ddr});
    end

    // ---------------- stimulus ----------------
    int          t_rdy, t_we_cyc, t_we_cnt, t_lm_cyc, t_dv_cnt;
    logic [15:0] t_rd;
    logic [7:0]  t_dd;

    // One request; optional keyboard strobe (ks[8]) presented in cycle 1.
    task automatic do_op(input logic w, input logic [15:0] a, input logic [15:0] d, input logic [8:0] ks);
        int c;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(negedge clk);
        req = 1'b0; we = 1'($urandom_range(0, 1)); addr = 16'($urandom); wdata = 16'($urandom);
        kb_strobe = ks[8]; kb_char = ks[7:0];
        c = 1; t_rdy = -1; t_we_cyc = -1; t_we_cnt = 0; t_lm_cyc = -1; t_dv_cnt = 0;
        t_rd = 16'h0; t_dd = 8'h0;
        while (c < 20 && t_rdy < 0) begin
            if (ldMAR && t_lm_cyc < 0) t_lm_cyc = c;
            if (memWE) begin t_we_cnt++; if (t_we_cyc < 0) t_we_cyc = c; end
            if (ddr_valid) begin t_dv_cnt++; t_dd = ddr_data; end
            if (ready) begin
                t_rdy = c; t_rd = rdata;
            end else begin
                @(negedge clk);
                kb_strobe = 1'b0;
                c++;
            end
        end
        kb_strobe = 1'b0;
        if (t_rdy < 0) chk("ready_timeout", 16'(c), 16'hFFFF);
    endtask

    task automatic kb_pulse(input logic [7:0] ch);
        @(negedge clk); kb_strobe = 1'b1; kb_char = ch;
        @(negedge clk); kb_strobe = 1'b0;
    endtask

    initial begin
        int nrdy, adj;
        bit prev;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_rdata", rdata, 16'h0000);
        chk("rst_busy", {15'b0, busy}, 16'h0);
        reset = 1'b0;

        // RAM write then read back
        do_op(1'b1, 16'h3000, 16'h1234, 9'h0);
        chk("wr_memWE_cyc", 16'(t_we_cyc), 16'd3);
        chk("wr_memWE_cnt", 16'(t_we_cnt), 16'd1);
        chk("wr_ready_cyc", 16'(t_rdy), 16'd4);
        do_op(1'b0, 16'h3000, 16'h0, 9'h0);
        chk("rd_ready_cyc", 16'(t_rdy), 16'd4);
        chk("rd_data", t_rd, 16'h1234);

        // Preload xBEEF at x3001 then read it
        do_op(1'b1, 16'h3001, 16'hBEEF, 9'h0);
        do_op(1'b0, 16'h3001, 16'h0, 9'h0);
        chk("rd2_ldMAR_cyc", 16'(t_lm_cyc), 16'd1);
        chk("rd2_data", t_rd, 16'hBEEF);

        // Keyboard
        kb_pulse(8'h41);
        do_op(1'b0, 16'hFE00, 16'h0, 9'h0);
        chk("kbsr_full", t_rd, 16'h8000);
        chk("io_ready_cyc", 16'(t_rdy), 16'd2);
        do_op(1'b0, 16'hFE02, 16'h0, 9'h0);
        chk("kbdr_41", t_rd, 16'h0041);
        do_op(1'b0, 16'hFE00, 16'h0, 9'h0);
        chk("kbsr_empty", t_rd, 16'h0000);
        kb_pulse(8'h41);
        kb_pulse(8'h42);
        do_op(1'b0, 16'hFE02, 16'h0, 9'h0);
        chk("kbdr_drop", t_rd, 16'h0041);
        // Strobe coinciding with a KBDR read
        kb_pulse(8'h43);
        do_op(1'b0, 16'hFE02, 16'h0, 9'h144);
        chk("kbdr_old", t_rd, 16'h0043);
        do_op(1'b0, 16'hFE00, 16'h0, 9'h0);
        chk("kbsr_still_full", t_rd, 16'h8000);
        do_op(1'b0, 16'hFE02, 16'h0, 9'h0);
        chk("kbdr_new", t_rd, 16'h0044);
        do_op(1'b0, 16'hFE08, 16'h0, 9'h0);
        chk("io_other", t_rd, 16'h0000);

        // Display
        dsp_ready = 1'b1;
        do_op(1'b0, 16'hFE04, 16'h0, 9'h0);
        chk("dsr", t_rd, 16'h8000);
        do_op(1'b1, 16'hFE06, 16'h0158, 9'h0);
        chk("ddr_ready_cyc", 16'(t_rdy), 16'd2);
        chk("ddr_pulses", 16'(t_dv_cnt), 16'd1);
        chk("ddr_char", {8'h0, t_dd}, 16'h0058);
        chk("ddr_no_ldMAR", 16'(t_lm_cyc), 16'hFFFF);
        chk("ddr_no_memWE", 16'(t_we_cnt), 16'd0);

        // req held high: accept every third cycle, never adjacent ready pulses
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 16'hFE04;
        nrdy = 0; adj = 0; prev = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (ready) begin nrdy++; if (prev) adj++; end
            prev = ready;
            if (i == 10) req = 1'b0;
        end
        chk("held_ready_cnt", 16'(nrdy), 16'd4);
        chk("held_adjacent", 16'(adj), 16'd0);

        // Reset during WR_LDMDR aborts the write
        do_op(1'b1, 16'h4000, 16'h5555, 9'h0);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 16'h4000; wdata = 16'hAAAA;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        chk("abort_in_wrldmdr", {15'b0, ldMDR}, 16'h1);
        #2 reset = 1'b1;
        #1 chk("abort_memWE", {15'b0, memWE}, 16'h0);
        chk("abort_busy", {15'b0, busy}, 16'h0);
        chk("abort_bus", bus_out, 16'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_ram_kept", ram[16'h4000], 16'h5555);
        do_op(1'b0, 16'h4000, 16'h0, 9'h0);
        chk("abort_readback", t_rd, 16'h5555);
        chk("abort_read_cyc", 16'(t_rdy), 16'd4);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
